// File: rtl/nor_netlist_sequencer.sv
// Programmable serial NOR2/INV netlist evaluator that evaluates one gate cell per cycle, following the MAGIC in-memory model.
// Optional NOR_SEQ_NOR3_EN: widens the instruction to {op[1:0], srcA, srcB, srcC} and adds a NOR3 opcode.
module nor_netlist_sequencer #(
    parameter int N_IN      = 7,
    parameter int MAX_GATES = 64,
    parameter int N_OUT     = 1,
    localparam int CELLS    = N_IN + MAX_GATES,
    localparam int IDXW     = $clog2(CELLS),
    localparam int GW       = $clog2(MAX_GATES + 1),
    localparam int AW       = $clog2(MAX_GATES),
    localparam int OSW      = (N_OUT > 1) ? $clog2(N_OUT) : 1
`ifdef NOR_SEQ_NOR3_EN
    , localparam int PW     = 2 + 3 * IDXW
`else
    , localparam int PW     = 1 + 2 * IDXW
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [PW-1:0]    prog_data,
    input  logic             out_we,
    input  logic [OSW-1:0]   out_sel,
    input  logic [IDXW-1:0]  out_idx,
    input  logic [GW-1:0]    n_gates,
    input  logic             start,
    input  logic [N_IN-1:0]  x,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] z,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_EVAL = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t             state_r;
    logic               busy_r;
    logic               done_r;
    logic [N_OUT-1:0]   z_r;
    logic               err_r;
    logic [CELLS-1:0]   cells_r;
    logic [GW-1:0]      g_r;
    logic [GW-1:0]      ng_r;
    logic [PW-1:0]      prog_mem_r [MAX_GATES];
    logic [IDXW-1:0]    outmap_r   [N_OUT];

    logic [PW-1:0]      ins_s;
    logic [IDXW-1:0]    src_a_s;
    logic [IDXW-1:0]    src_b_s;
    logic               gate_val_s;
    logic               gate_err_s;
    logic [IDXW-1:0]    tgt_s;
    logic [N_OUT-1:0]   z_next_s;
    logic               out_err_s;
    logic               ng_over_s;
    logic [GW-1:0]      ng_clamp_s;

    function automatic logic idx_ok(input logic [IDXW-1:0] i);
        return (32'(i) < 32'(CELLS));
    endfunction

    // Out-of-range cell reads return 0; the caller flags them separately.
    function automatic logic rd_cell(input logic [CELLS-1:0] c, input logic [IDXW-1:0] i);
        logic v;
        if (idx_ok(i)) begin
            v = c[i];
        end else begin
            v = 1'b0;
        end
        return v;
    endfunction

    assign busy = busy_r;
    assign done = done_r;
    assign z    = z_r;
    assign err  = err_r;

    // Requested gate count clamped to the program depth.
    always_comb begin
        ng_over_s  = (32'(n_gates) > 32'(MAX_GATES));
        ng_clamp_s = n_gates;
        if (ng_over_s) begin
            ng_clamp_s = GW'(MAX_GATES);
        end else begin
            ng_clamp_s = n_gates;
        end
    end

    // Decode and evaluate the gate selected by the gate counter.
    always_comb begin
        ins_s      = prog_mem_r[g_r[AW-1:0]];
        tgt_s      = IDXW'(N_IN) + IDXW'(g_r);
        gate_val_s = 1'b0;
        gate_err_s = 1'b0;
`ifdef NOR_SEQ_NOR3_EN
        src_a_s = ins_s[3*IDXW-1 -: IDXW];
        src_b_s = ins_s[2*IDXW-1 -: IDXW];
        case (ins_s[PW-1 -: 2])
            2'd0: begin
                gate_val_s = ~(rd_cell(cells_r, src_a_s) | rd_cell(cells_r, src_b_s));
                gate_err_s = ~idx_ok(src_a_s) | ~idx_ok(src_b_s);
            end
            2'd1: begin
                gate_val_s = ~rd_cell(cells_r, src_a_s);
                gate_err_s = ~idx_ok(src_a_s);
            end
            2'd2: begin
                gate_val_s = ~(rd_cell(cells_r, src_a_s) | rd_cell(cells_r, src_b_s)
                               | rd_cell(cells_r, ins_s[IDXW-1:0]));
                gate_err_s = ~idx_ok(src_a_s) | ~idx_ok(src_b_s) | ~idx_ok(ins_s[IDXW-1:0]);
            end
            default: begin
                gate_val_s = ~rd_cell(cells_r, src_a_s);
                gate_err_s = 1'b1;
            end
        endcase
`else
        src_a_s = ins_s[2*IDXW-1 -: IDXW];
        src_b_s = ins_s[IDXW-1:0];
        if (ins_s[PW-1] == 1'b0) begin
            gate_val_s = ~(rd_cell(cells_r, src_a_s) | rd_cell(cells_r, src_b_s));
            gate_err_s = ~idx_ok(src_a_s) | ~idx_ok(src_b_s);
        end else begin
            gate_val_s = ~rd_cell(cells_r, src_a_s);
            gate_err_s = ~idx_ok(src_a_s);
        end
`endif
    end

    // Output map lookup used when the run finishes.
    always_comb begin
        z_next_s  = '0;
        out_err_s = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            z_next_s[k] = rd_cell(cells_r, outmap_r[k]);
            out_err_s   = out_err_s | ~idx_ok(outmap_r[k]);
        end
    end

    // Program and output-map memories, writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_GATES; i++) begin
                prog_mem_r[i] <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                outmap_r[k] <= '0;
            end
        end else begin
            if ((state_r == ST_IDLE) && prog_we) begin
                prog_mem_r[prog_addr] <= prog_data;
            end
            if ((state_r == ST_IDLE) && out_we && (32'(out_sel) < 32'(N_OUT))) begin
                outmap_r[out_sel] <= out_idx;
            end
        end
    end

    // Sequencer FSM with registered status outputs and the cell array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            z_r     <= '0;
            err_r   <= 1'b0;
            cells_r <= '0;
            g_r     <= '0;
            ng_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cells_r[N_IN-1:0] <= x;
                        ng_r              <= ng_clamp_s;
                        err_r             <= ng_over_s;
                        busy_r            <= 1'b1;
                        state_r           <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    cells_r[CELLS-1:N_IN] <= '1;
                    g_r                   <= '0;
                    if (ng_r == '0) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_FIN;
                    end else begin
                        state_r <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    cells_r[tgt_s] <= gate_val_s;
                    err_r          <= err_r | gate_err_s;
                    g_r            <= g_r + GW'(1);
                    if (g_r == (ng_r - GW'(1))) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    z_r     <= z_next_s;
                    err_r   <= err_r | out_err_s;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nor_netlist_sequencer.sv
// Directed, table-driven bench for nor_netlist_sequencer (default parameters).
module tb_nor_netlist_sequencer;

    localparam int IDXW = 7;
`ifdef NOR_SEQ_NOR3_EN
    localparam int PW = 2 + 3 * IDXW;
`else
    localparam int PW = 1 + 2 * IDXW;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [5:0]    prog_addr = '0;
    logic [PW-1:0] prog_data = '0;
    logic          out_we = 1'b0;
    logic [0:0]    out_sel = '0;
    logic [6:0]    out_idx = '0;
    logic [6:0]    n_gates = '0;
    logic          start = 1'b0;
    logic [6:0]    x = '0;
    logic          busy;
    logic          done;
    logic [0:0]    z;
    logic          err;

    int total = 0;
    int passed = 0;

    nor_netlist_sequencer dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .out_we(out_we), .out_sel(out_sel), .out_idx(out_idx),
        .n_gates(n_gates), .start(start), .x(x), .busy(busy), .done(done), .z(z), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] xv;
        logic [6:0] nv;
        logic [6:0] oi;
        logic       ez;
        logic       ee;
        int         ecyc;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [PW-1:0] enc(input int op, input int a, input int b);
`ifdef NOR_SEQ_NOR3_EN
        return {2'(op), 7'(a), 7'(b), 7'd0};
`else
        return {1'(op), 7'(a), 7'(b)};
`endif
    endfunction

    task automatic wr_prog(input int addr, input int op, input int a, input int b);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 6'(addr); prog_data = enc(op, a, b);
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic wr_out(input logic [6:0] oi);
        @(negedge clk);
        out_we = 1'b1; out_sel = 1'b0; out_idx = oi;
        @(posedge clk); #1;
        out_we = 1'b0;
    endtask

    // cyc is the cycle number of done, counting the cycle after the start edge as 1.
    task automatic run_case(input logic [6:0] xv, input logic [6:0] nv, input logic [6:0] oi,
                            input bit set_map, output logic zv, output logic ev, output int cyc);
        if (set_map) wr_out(oi);
        @(negedge clk);
        x = xv; n_gates = nv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = i + 1;
                break;
            end
        end
        zv = z;
        ev = err;
    endtask

    initial begin
        logic zv;
        logic ev;
        int   cyc;
        int   ndone;

        // x, n_gates, out_idx, z, err, done cycle
        vecs[0] = '{7'b0000011, 7'd3,  7'd9,  1'b1, 1'b0, 6};
        vecs[1] = '{7'b0000001, 7'd3,  7'd9,  1'b0, 1'b0, 6};
        vecs[2] = '{7'b0000010, 7'd3,  7'd9,  1'b0, 1'b0, 6};
        vecs[3] = '{7'b0000100, 7'd0,  7'd2,  1'b1, 1'b0, 3};
        vecs[4] = '{7'b0000011, 7'd3,  7'd8,  1'b0, 1'b0, 6};
        vecs[5] = '{7'b0000001, 7'd2,  7'd8,  1'b1, 1'b0, 5};
        vecs[6] = '{7'b0000000, 7'd3,  7'd72, 1'b0, 1'b1, 6};
        vecs[7] = '{7'b0000011, 7'd1,  7'd8,  1'b1, 1'b0, 4};
        vecs[8] = '{7'b0000011, 7'd4,  7'd10, 1'b0, 1'b0, 7};
        vecs[9] = '{7'b0000011, 7'd65, 7'd9,  1'b1, 1'b1, 67};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_z", z, 0);
        chk("reset_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // AND netlist plus a forward-referencing gate in slot 3.
        wr_prog(0, 1, 0, 0);
        wr_prog(1, 1, 1, 0);
        wr_prog(2, 0, 7, 8);
        wr_prog(3, 0, 11, 11);

        for (int v = 0; v < 10; v++) begin
            run_case(vecs[v].xv, vecs[v].nv, vecs[v].oi, 1'b1, zv, ev, cyc);
            chk($sformatf("vec%0d_z", v), zv, vecs[v].ez);
            chk($sformatf("vec%0d_err", v), ev, vecs[v].ee);
            chk($sformatf("vec%0d_cycle", v), cyc, vecs[v].ecyc);
        end

        // Self/forward reference reads the init value 1.
        wr_prog(0, 0, 8, 8);
        run_case(7'b0000000, 7'd1, 7'd7, 1'b1, zv, ev, cyc);
        chk("fwd_z", zv, 0);
        chk("fwd_err", ev, 0);
        chk("fwd_cycle", cyc, 4);

        // start and prog_we during EVAL must be ignored.
        wr_prog(0, 1, 0, 0);
        wr_out(7'd9);
        @(negedge clk);
        x = 7'b0000011; n_gates = 7'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; x = 7'b0000000; n_gates = 7'd0;
        prog_we = 1'b1; prog_addr = 6'd2; prog_data = enc(1, 0, 0);
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0;
        chk("busy_in_eval", busy, 1);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("single_done", ndone, 1);
        chk("ignored_start_z", z, 1);
        chk("idle_after_run", busy, 0);
        run_case(7'b0000011, 7'd3, 7'd9, 1'b0, zv, ev, cyc);
        chk("prog_unchanged_z", zv, 1);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        x = 7'b0000011; n_gates = 7'd65; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrun_err_set", err, 1);
        chk("midrun_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_z", z, 0);
        chk("arst_err", err, 0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Memories cleared: output map reads cell 0, gates are NOR2(cell0, cell0).
        run_case(7'b0000101, 7'd2, 7'd0, 1'b0, zv, ev, cyc);
        chk("post_rst_z", zv, 1);
        chk("post_rst_err", ev, 0);
        chk("post_rst_cycle", cyc, 5);
        run_case(7'b0000101, 7'd1, 7'd7, 1'b1, zv, ev, cyc);
        chk("post_rst_gate_z", zv, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nor_netlist_sequencer.md
Name: nor_netlist_sequencer

Overview:
- Programmable serial evaluator for NOR2/INV-mapped logic netlists, mirroring the in-memory MAGIC execution model: inputs are written to cells, gate cells are initialised to 1, then one gate is evaluated per cycle.
- Replaces fixed, per-function combinational netlists with one parametrised engine; any mapped function of up to N_IN inputs, MAX_GATES gates and N_OUT outputs is loaded as a program.

Parameters:
- N_IN, 7, number of primary inputs (cells 0..N_IN-1)
- MAX_GATES, 64, gate program depth (gate g writes cell N_IN+g)
- N_OUT, 1, number of primary outputs
- CELLS, N_IN+MAX_GATES, derived: cell array size
- IDXW, $clog2(CELLS), derived: cell index width
- GW, $clog2(MAX_GATES+1), derived: gate count width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- prog_we  in  1  program write strobe (ignored unless IDLE)
- prog_addr  in  $clog2(MAX_GATES)  gate slot
- prog_data  in  1+2*IDXW  {op, srcA, srcB}; op 0=NOR2, 1=INV(srcA)
- out_we  in  1  output map write strobe (ignored unless IDLE)
- out_sel  in  $clog2(N_OUT)  output slot
- out_idx  in  IDXW  cell driving that output
- n_gates  in  GW  gates to execute, sampled at start
- start  in  1  begin evaluation (accepted only in IDLE)
- x  in  N_IN  primary inputs, sampled at start
- busy  out  1  high INIT..EVAL
- done  out  1  one-cycle pulse when z updates
- z  out  N_OUT  registered results, held until next done
- err  out  1  sticky: out-of-range index encountered; cleared at start

Behaviour:
- Reset: state IDLE, busy=0, done=0, z=0, err=0, cells and gate counter 0; program and output map memories also cleared: every gate reads NOR2(cell0, cell0), every output reads cell 0.
- FSM IDLE -> INIT -> EVAL -> FIN -> IDLE.
- IDLE: start=1 captures x into cells[0..N_IN-1], latches n_gates, clears err, goes INIT. prog_we/out_we write memories only in IDLE.
- INIT (1 cycle): all gate cells set to 1 (MAGIC output-cell init). Gate counter g=0.
- EVAL: per cycle, cell[N_IN+g] <= NOR2 ? ~(c[srcA]|c[srcB]) : ~c[srcA]; g++. Leaves after gate n_gates-1. n_gates=0 -> EVAL skipped, INIT goes straight to FIN.
- n_gates > MAX_GATES: clamped to MAX_GATES, err set.
- Forward/self reference (src >= N_IN+g) reads the current cell value (1 if not yet evaluated); defined, not an error.
- Source or out_idx >= CELLS reads 0 and sets err.
- FIN (1 cycle): z[k] <= cell[outmap[k]] for all k; done=1 next cycle, busy=0 from entering FIN.
- Latency: start accepted at edge T -> done high in cycle T+n_gates+3 (INIT, n_gates EVAL, FIN, done).
- start while busy: ignored. prog/out writes while busy: dropped.
- Async reset mid-run: immediate return to reset state; no done pulse.

Optional Feature:
- Macro NOR_SEQ_NOR3_EN. Defined: prog_data widens to 2+3*IDXW {op[1:0], srcA, srcB, srcC}; op 2 = NOR3 ~(a|b|c); op 3 reserved, executes as INV and sets err. Undefined: format as above, NOR2/INV only.

Test Plan:
- AND via 3 gates: g0=INV(0), g1=INV(1), g2=NOR2(7,8), out0->9, n_gates=3; x=7'b0000011 -> z=1; x=7'b0000001 -> z=0; done exactly 6 cycles after start edge.
- n_gates=0, out0->cell 2, x=7'b0000100 -> z=1, done 3 cycles after start, err=0.
- Forward reference: g0=NOR2(8,8), n_gates=1, out0->7 -> z=0 (reads init 1); err=0.
- Out-of-range: out0->CELLS+1 (if representable) or n_gates=MAX_GATES+1 -> err=1 after run; next start clears err.
- start pulsed during EVAL and prog_we during EVAL -> no restart, program unchanged, single done pulse.
- rst_n low during EVAL -> busy=0, z=0, err=0 immediately; no done; fresh start after release completes normally.
